// File: rtl/masked_prng_bank_if.sv
// Handshake/bus bundle for masked_prng_bank.
// Purpose : carries seeds and control into the PRNG bank, and random words and status back out.
// Signals : init_i       - load seeds and restart the warm-up
//           seed_i       - NUM_CH concatenated WIDTH-bit seeds
//           ready_i      - consumer accepts prng_o this cycle
//           valid_o      - prng_o holds a fresh random word
//           prng_o       - NUM_CH concatenated LFSR states
//           seed_err_o   - a zero seed was substituted at the last init
//           reseed_req_o - enough words were delivered that a reseed is due
// Modports: master (seed source / consumer side), slave (the PRNG bank).
interface masked_prng_bank_if #(
  parameter int WIDTH  = 128,
  parameter int NUM_CH = 2
);
  logic                    init_i;
  logic [NUM_CH*WIDTH-1:0] seed_i;
  logic                    ready_i;
  logic                    valid_o;
  logic [NUM_CH*WIDTH-1:0] prng_o;
  logic                    seed_err_o;
  logic                    reseed_req_o;

  modport master (
    output init_i, seed_i, ready_i,
    input  valid_o, prng_o, seed_err_o, reseed_req_o
  );

  modport slave (
    input  init_i, seed_i, ready_i,
    output valid_o, prng_o, seed_err_o, reseed_req_o
  );
endinterface

// File: rtl/masked_prng_bank.sv
// Multi-channel Fibonacci-LFSR randomness source for masked crypto datapaths.
// Purpose: delivers NUM_CH independent WIDTH-bit random words per valid/ready
//          handshake, with a post-seed warm-up, zero-seed substitution and a
//          sticky reseed request after RESEED_INTERVAL delivered words.
// Ports  : clk - clock
//          rst - synchronous active-high reset
//          bus - masked_prng_bank_if slave modport (seeds, handshake, status)
module masked_prng_bank #(
  parameter int               WIDTH           = 128,
  parameter int               NUM_CH          = 2,
  parameter logic [WIDTH-1:0] TAPS            = WIDTH'(128'hA000_0028_0000_0000_0000_0000_0000_0000),
  parameter logic [WIDTH-1:0] ZERO_SUB        = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               WARMUP_CYCLES   = 16,
  parameter int               RESEED_INTERVAL = 1024
) (
  input logic               clk,
  input logic               rst,
  masked_prng_bank_if.slave bus
);

  localparam int WW = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam int CW = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;
  localparam logic [WW-1:0] WARM_LOAD = WW'(WARMUP_CYCLES);
  localparam logic [CW-1:0] CNT_MAX   = CW'(RESEED_INTERVAL);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t                  state_reg, state_next;
  logic [WW-1:0]           warm_cnt_reg;
  logic [CW-1:0]           word_cnt_reg;
  logic                    seed_err_reg;
  logic                    reseed_reg;
  logic [NUM_CH-1:0]       zero_vec;
  logic [NUM_CH*WIDTH-1:0] prng_all;
  logic                    step_en;
  logic                    handshake;

  // An init in the same cycle as ready_i wins: the word is neither counted nor consumed.
  assign handshake = (state_reg == RUN) & bus.ready_i & ~bus.init_i;
  assign step_en   = ~bus.init_i & ((state_reg == WARMUP) | handshake);

  // Per-channel LFSR with zero-seed substitution (an all-zero state would lock up).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] seed_ch;
      logic [WIDTH-1:0] lfsr_reg;

      assign seed_ch      = bus.seed_i[gi*WIDTH +: WIDTH];
      assign zero_vec[gi] = (seed_ch == '0);
      assign prng_all[gi*WIDTH +: WIDTH] = lfsr_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          lfsr_reg <= '0;
        end else if (bus.init_i) begin
          lfsr_reg <= zero_vec[gi] ? ZERO_SUB : seed_ch;
        end else if (step_en) begin
          lfsr_reg <= {lfsr_reg[WIDTH-2:0], ^(lfsr_reg & TAPS)};
        end
      end
    end
  endgenerate

  // Next-state logic; init overrides whatever the current state would do.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = IDLE;
      WARMUP:  if (warm_cnt_reg <= WW'(1)) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (bus.init_i) begin
      state_next = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      warm_cnt_reg <= '0;
      word_cnt_reg <= '0;
      seed_err_reg <= 1'b0;
      reseed_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (bus.init_i) begin
        warm_cnt_reg <= WARM_LOAD;
        word_cnt_reg <= '0;
        seed_err_reg <= |zero_vec;
        reseed_reg   <= 1'b0;
      end else begin
        if (state_reg == WARMUP) begin
          warm_cnt_reg <= warm_cnt_reg - WW'(1);
        end
        // Counter saturates at the interval; the request is raised by the
        // handshake that takes it there and then stays until the next init.
        if ((RESEED_INTERVAL != 0) && handshake && (word_cnt_reg != CNT_MAX)) begin
          word_cnt_reg <= word_cnt_reg + CW'(1);
          if (word_cnt_reg == CNT_MAX - CW'(1)) begin
            reseed_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.valid_o      = (state_reg == RUN);
  assign bus.prng_o       = prng_all;
  assign bus.seed_err_o   = seed_err_reg;
  assign bus.reseed_req_o = reseed_reg;

endmodule

// File: tb/tb_masked_prng_bank.sv
// Directed self-checking bench for masked_prng_bank.
// Instance A: WIDTH=8, NUM_CH=1, TAPS=8'hB8, WARMUP_CYCLES=2, RESEED_INTERVAL=4.
// Instance B: default 128-bit, 2-channel configuration.
module tb_masked_prng_bank;

  localparam logic [127:0] TAPS_B = 128'hA000_0028_0000_0000_0000_0000_0000_0000;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_assert;
  int   n_fail;

  masked_prng_bank_if #(.WIDTH(8),   .NUM_CH(1)) a_if ();
  masked_prng_bank_if #(.WIDTH(128), .NUM_CH(2)) b_if ();

  masked_prng_bank #(
    .WIDTH(8), .NUM_CH(1), .TAPS(8'hB8), .ZERO_SUB(8'h01),
    .WARMUP_CYCLES(2), .RESEED_INTERVAL(4)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(a_if.slave)
  );

  masked_prng_bank dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] step_b(input logic [127:0] v);
    return {v[126:0], ^(v & TAPS_B)};
  endfunction

  initial begin
    logic [7:0]   exp_seq [3];
    logic         zero_seen;
    logic [127:0] m0, m1;
    n_assert = 0;
    n_fail   = 0;
    exp_seq[0] = 8'h04; exp_seq[1] = 8'h08; exp_seq[2] = 8'h11;

    rst_a = 1'b1; rst_b = 1'b1;
    a_if.init_i = 1'b0; a_if.seed_i = '0; a_if.ready_i = 1'b0;
    b_if.init_i = 1'b0; b_if.seed_i = '0; b_if.ready_i = 1'b0;
    tick(); tick();
    rst_a = 1'b0;

    // Reset state
    chk("rst_valid",   a_if.valid_o, 0);
    chk("rst_prng",    a_if.prng_o, 0);
    chk("rst_seed_err", a_if.seed_err_o, 0);
    chk("rst_reseed",  a_if.reseed_req_o, 0);

    // IDLE ignores ready
    a_if.ready_i = 1'b1; tick(); a_if.ready_i = 1'b0;
    chk("idle_hold", {a_if.valid_o, a_if.prng_o}, 9'h000);

    // Warm-up from seed 01
    a_if.init_i = 1'b1; a_if.seed_i = 8'h01; tick(); a_if.init_i = 1'b0;
    chk("warm_e0", {a_if.valid_o, a_if.prng_o}, {1'b0, 8'h01});
    tick();
    chk("warm_e1", {a_if.valid_o, a_if.prng_o}, {1'b0, 8'h02});
    tick();
    chk("warm_e2", {a_if.valid_o, a_if.prng_o}, {1'b1, 8'h04});
    tick();
    chk("run_hold", a_if.prng_o, 8'h04);

    // Three handshakes
    a_if.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hs_word%0d", i), a_if.prng_o, exp_seq[i]);
      tick();
    end
    a_if.ready_i = 1'b0;
    chk("after_hs", a_if.prng_o, 8'h23);
    tick();
    chk("stall_hold", a_if.prng_o, 8'h23);
    chk("reseed_3hs", a_if.reseed_req_o, 0);

    // Fourth handshake reaches the reseed interval
    a_if.ready_i = 1'b1; tick(); a_if.ready_i = 1'b0;
    chk("reseed_4hs", {a_if.reseed_req_o, a_if.valid_o, a_if.prng_o}, {1'b1, 1'b1, 8'h47});
    a_if.ready_i = 1'b1; tick(); a_if.ready_i = 1'b0;
    chk("reseed_sticky", {a_if.reseed_req_o, a_if.valid_o}, 2'b11);

    // init with ready in RUN: no step, reload, clear reseed
    a_if.ready_i = 1'b1; a_if.init_i = 1'b1; a_if.seed_i = 8'h5A; tick();
    a_if.ready_i = 1'b0; a_if.init_i = 1'b0;
    chk("prio_load", {a_if.valid_o, a_if.reseed_req_o, a_if.seed_err_o, a_if.prng_o},
        {3'b000, 8'h5A});
    tick();
    chk("prio_e1_valid", a_if.valid_o, 0);
    tick();
    chk("prio_e2", {a_if.valid_o, a_if.prng_o}, {1'b1, 8'h69});

    // Zero seed substitution
    a_if.init_i = 1'b1; a_if.seed_i = 8'h00; tick(); a_if.init_i = 1'b0;
    chk("zero_load", {a_if.seed_err_o, a_if.prng_o}, {1'b1, 8'h01});
    tick(); tick();
    chk("zero_run", {a_if.valid_o, a_if.prng_o}, {1'b1, 8'h04});

    // Full period: 255 handshakes return to 04, never 00
    zero_seen = 1'b0;
    a_if.ready_i = 1'b1;
    for (int i = 0; i < 255; i++) begin
      if (a_if.prng_o == 8'h00) zero_seen = 1'b1;
      tick();
    end
    a_if.ready_i = 1'b0;
    chk("period_wrap", a_if.prng_o, 8'h04);
    chk("period_no_zero", zero_seen, 0);
    chk("period_status", {a_if.valid_o, a_if.reseed_req_o, a_if.seed_err_o}, 3'b111);

    // Nonzero seed clears seed_err
    a_if.init_i = 1'b1; a_if.seed_i = 8'h5A; tick(); a_if.init_i = 1'b0;
    chk("seed_err_clear", {a_if.seed_err_o, a_if.reseed_req_o}, 2'b00);

    // Reset in the middle of warm-up
    a_if.init_i = 1'b1; a_if.seed_i = 8'h00; tick(); a_if.init_i = 1'b0;
    tick();
    chk("pre_rst_err", a_if.seed_err_o, 1);
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    chk("rst_warm", {a_if.valid_o, a_if.seed_err_o, a_if.reseed_req_o, a_if.prng_o}, 11'h000);
    tick(); tick();
    chk("rst_idle", {a_if.valid_o, a_if.prng_o}, 9'h000);

    // Config B: two 128-bit channels with distinct seeds
    rst_b = 1'b0;
    tick();
    chk("b_rst", {b_if.valid_o, b_if.prng_o}, 257'h0);
    m0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    m1 = 128'hDEAD_BEEF_0BAD_F00D_C0FF_EE00_1234_5678;
    b_if.init_i = 1'b1; b_if.seed_i = {m1, m0}; tick(); b_if.init_i = 1'b0;
    chk("b_load", b_if.prng_o, {m1, m0});
    for (int i = 0; i < 15; i++) begin
      tick();
      m0 = step_b(m0); m1 = step_b(m1);
    end
    chk("b_warm15_valid", b_if.valid_o, 0);
    tick();
    m0 = step_b(m0); m1 = step_b(m1);
    chk("b_warm16", {b_if.valid_o, b_if.prng_o}, {1'b1, m1, m0});
    b_if.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      m0 = step_b(m0); m1 = step_b(m1);
      chk($sformatf("b_hs%0d", i), b_if.prng_o, {m1, m0});
    end
    b_if.ready_i = 1'b0;

    // Config B: zero seed only on channel 1
    m0 = 128'h0000_0000_0000_0000_0000_0000_0000_00A5;
    b_if.init_i = 1'b1; b_if.seed_i = {128'h0, m0}; tick(); b_if.init_i = 1'b0;
    chk("b_zero_ch1", {b_if.seed_err_o, b_if.prng_o}, {1'b1, 128'h1, m0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
